// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the single-issue MIPS core: paces PcUnit against imem handshakes,
// downstream stalls and decode redirects, and halts at the end of the program image.
module fetch_sequencer #(
  parameter logic [31:0] END_ADDR    = 32'h0000_006c,
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             PcReSet,
  input  logic [31:0]      pc,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             instr_valid,
  input  logic             stall_req,
  input  logic             br_req,
  input  logic [31:0]      br_offset,
  input  logic             j_req,
  input  logic [25:0]      j_target,
  output logic             pause,
  output logic             PcSel,
  output logic [31:0]      Adress,
  output logic             Jump,
  output logic [25:0]      Jumpaddr,
  output logic             flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STALL,
    S_ADV,
    S_HALT
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              pend_j, pend_j_n;
  logic              pend_b, pend_b_n;
  logic [25:0]       pend_jt, pend_jt_n;
  logic [31:0]       pend_bo, pend_bo_n;

  logic              imem_req_n, instr_valid_n, pause_n, PcSel_n, Jump_n;
  logic              flush_n, halted_n, mem_err_n;
  logic [31:0]       Adress_n;
  logic [25:0]       Jumpaddr_n;
  logic [CNT_W-1:0]  redirect_cnt_n;

  always_comb begin
    state_n        = state;
    tcnt_n         = tcnt;
    pend_j_n       = pend_j;
    pend_b_n       = pend_b;
    pend_jt_n      = pend_jt;
    pend_bo_n      = pend_bo;
    mem_err_n      = mem_err;
    redirect_cnt_n = redirect_cnt;

    case (state)
      S_IDLE:  state_n = S_REQ;
      S_REQ: begin
        if ((pc >= END_ADDR) && !pend_j && !pend_b) begin
          state_n = S_HALT;
        end else if (imem_ack) begin
          tcnt_n  = '0;
          state_n = stall_req ? S_STALL : S_ADV;
        end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
          state_n   = S_HALT;
          mem_err_n = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      S_STALL: if (!stall_req) state_n = S_ADV;
      S_ADV: begin
        state_n  = S_REQ;
        pend_j_n = 1'b0;
        pend_b_n = 1'b0;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase

    if ((state_n == S_REQ) && (state != S_REQ)) tcnt_n = '0;

    // Capture after the ADV clear so a redirect arriving in the advance cycle survives to the next one.
    if (state != S_HALT) begin
      if (j_req) begin
        pend_j_n  = 1'b1;
        pend_jt_n = j_target;
      end else if (br_req) begin
        pend_b_n  = 1'b1;
        pend_bo_n = br_offset;
      end
    end

    imem_req_n    = (state_n == S_REQ);
    instr_valid_n = (state_n == S_ADV);
    pause_n       = (state_n != S_ADV);
    halted_n      = (state_n == S_HALT);
    PcSel_n       = 1'b0;
    Jump_n        = 1'b0;
    Adress_n      = '0;
    Jumpaddr_n    = '0;
    flush_n       = 1'b0;

    // Outputs are registered, so the redirect shown during ADV is chosen on the edge entering it.
    if ((state_n == S_ADV) && (pend_j_n || pend_b_n)) begin
      flush_n = 1'b1;
      if (pend_j_n) begin
        Jump_n     = 1'b1;
        Jumpaddr_n = pend_jt_n;
      end else begin
        PcSel_n  = 1'b1;
        Adress_n = pend_bo_n;
      end
      if (redirect_cnt != '1) redirect_cnt_n = redirect_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (PcReSet) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      pend_j       <= 1'b0;
      pend_b       <= 1'b0;
      pend_jt      <= '0;
      pend_bo      <= '0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      pause        <= 1'b1;
      PcSel        <= 1'b0;
      Jump         <= 1'b0;
      Adress       <= '0;
      Jumpaddr     <= '0;
      flush        <= 1'b0;
      halted       <= 1'b0;
      mem_err      <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_n;
      tcnt         <= tcnt_n;
      pend_j       <= pend_j_n;
      pend_b       <= pend_b_n;
      pend_jt      <= pend_jt_n;
      pend_bo      <= pend_bo_n;
      imem_req     <= imem_req_n;
      instr_valid  <= instr_valid_n;
      pause        <= pause_n;
      PcSel        <= PcSel_n;
      Jump         <= Jump_n;
      Adress       <= Adress_n;
      Jumpaddr     <= Jumpaddr_n;
      flush        <= flush_n;
      halted       <= halted_n;
      mem_err      <= mem_err_n;
      redirect_cnt <= redirect_cnt_n;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a PcUnit stand-in, an imem/decode driver, and a scoreboard
// checking every advance against a behavioural model of redirects and PC flow.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        PcReSet = 1'b1;
  logic [31:0] pc;
  logic        imem_req, imem_ack = 1'b0, instr_valid, stall_req = 1'b0;
  logic        br_req = 1'b0, j_req = 1'b0;
  logic [31:0] br_offset = '0;
  logic [25:0] j_target = '0;
  logic        pause, PcSel, Jump, flush, halted, mem_err;
  logic [31:0] Adress;
  logic [25:0] Jumpaddr;
  logic [15:0] redirect_cnt;
  logic [31:0] pc4;

  always #5 clk = ~clk;

  fetch_sequencer #(.END_ADDR(32'h0000_006c), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .PcReSet(PcReSet), .pc(pc), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .stall_req(stall_req), .br_req(br_req), .br_offset(br_offset),
    .j_req(j_req), .j_target(j_target), .pause(pause), .PcSel(PcSel), .Adress(Adress),
    .Jump(Jump), .Jumpaddr(Jumpaddr), .flush(flush), .halted(halted), .mem_err(mem_err),
    .redirect_cnt(redirect_cnt)
  );

  // PcUnit stand-in: applies whatever the sequencer drives, so pc reflects the DUT's decisions.
  assign pc4 = pc + 32'd4;
  always @(posedge clk) begin
    if (PcReSet) pc <= '0;
    else if (!pause) begin
      if (Jump)       pc <= {pc4[31:28], Jumpaddr, 2'b00};
      else if (PcSel) pc <= pc4 + (Adress << 2);
      else            pc <= pc4;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        j;
    logic [25:0] jt;
    logic        b;
    logic [31:0] bo;
    logic        fl;
    logic [15:0] cnt;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   waited;

  logic        m_pj, m_pb;
  logic [25:0] m_jt;
  logic [31:0] m_bo, m_pc;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!PcReSet) begin
      if (pause === 1'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_advance: pause=0 at cycle %0d with nothing expected", cyc);
        end else begin
          e_mon = sbq.pop_front();
          chk("adv_cycle", 64'(cyc), 64'(e_mon.cyc));
          chk("adv_jump", Jump, e_mon.j);
          chk("adv_jaddr", Jumpaddr, e_mon.jt);
          chk("adv_pcsel", PcSel, e_mon.b);
          chk("adv_adress", Adress, e_mon.bo);
          chk("adv_flush", flush, e_mon.fl);
          chk("adv_valid_noreq", {instr_valid, imem_req}, 2'b10);
          chk("adv_cnt", redirect_cnt, e_mon.cnt);
          chk("adv_pc", pc, e_mon.pc);
        end
      end else begin
        chk("quiet_flags", {instr_valid, PcSel, Jump, flush}, '0);
        chk("quiet_operands", {Adress, Jumpaddr}, '0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    br_req = 1'b0;
    j_req  = 1'b0;
  endtask

  task automatic inject(input logic [1:0] kind, input logic [31:0] off, input logic [25:0] tgt);
    if (kind != 2'b00) begin
      br_req    = kind[0];
      j_req     = kind[1];
      br_offset = off;
      j_target  = tgt;
      if (kind[1]) begin
        m_pj = 1'b1;
        m_jt = tgt;
      end else begin
        m_pb = 1'b1;
        m_bo = off;
      end
    end
  endtask

  task automatic push_exp();
    exp_t        e;
    logic [31:0] np;
    e.cyc = cyc + 1;
    e.j   = m_pj;
    e.jt  = m_pj ? m_jt : '0;
    e.b   = !m_pj && m_pb;
    e.bo  = e.b ? m_bo : '0;
    e.fl  = m_pj || m_pb;
    if (e.fl && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
    e.cnt = m_cnt;
    e.pc  = m_pc;
    np    = m_pc + 32'd4;
    if (m_pj)      m_pc = {np[31:28], m_jt, 2'b00};
    else if (m_pb) m_pc = np + (m_bo << 2);
    else           m_pc = np;
    m_pj = 1'b0;
    m_pb = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic do_reset(input int n);
    PcReSet   = 1'b1;
    imem_ack  = 1'b0;
    stall_req = 1'b0;
    br_req    = 1'b0;
    j_req     = 1'b0;
    repeat (n) @(negedge clk);
    sbq.delete();
    m_pj = 1'b0; m_pb = 1'b0; m_jt = '0; m_bo = '0; m_pc = '0; m_cnt = '0;
    chk("rst_pause", pause, 1'b1);
    chk("rst_flags", {imem_req, instr_valid, PcSel, Jump, flush, halted, mem_err}, '0);
    chk("rst_operands", {Adress, Jumpaddr}, '0);
    chk("rst_cnt", redirect_cnt, '0);
    PcReSet = 1'b0;
  endtask

  task automatic wait_req();
    waited = 0;
    do begin
      tick();
      waited++;
    end while (imem_req !== 1'b1 && waited < 6);
  endtask

  // when: 1 = first request cycle, 2 = ack cycle, 3 = first stall cycle, 4 = advance cycle.
  task automatic do_fetch(input int d, input int s, input logic [1:0] kind, input int when,
                          input logic [31:0] off, input logic [25:0] tgt);
    wait_req();
    chk("req_seen", imem_req, 1'b1);
    if (imem_req === 1'b1) begin
      for (int i = 0; i <= d; i++) begin
        if (i > 0) begin
          tick();
          chk("req_held", imem_req, 1'b1);
        end
        imem_ack  = (i == d);
        stall_req = (i == d) && (s > 0);
        if ((when == 1 && i == 0) || ((when == 2 || (when == 3 && s == 0)) && i == d))
          inject(kind, off, tgt);
        if (i == d && s == 0) push_exp();
      end
      for (int k = 1; k <= s; k++) begin
        tick();
        imem_ack = 1'b0;
        chk("stall_hold", {imem_req, pause}, 2'b01);
        stall_req = (k < s);
        if (when == 3 && k == 1) inject(kind, off, tgt);
        if (k == s) push_exp();
      end
      tick();
      imem_ack  = 1'b0;
      stall_req = 1'b0;
      if (when == 4) inject(kind, off, tgt);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic        ok;
    logic [1:0]  kind;
    int          d, s, when;

    // Reset, then back-to-back single-cycle fetches.
    do_reset(3);
    do_fetch(0, 0, 2'b00, 0, '0, '0);
    chk("req_after_reset", 64'(waited), 64'd1);
    do_fetch(0, 0, 2'b00, 0, '0, '0);
    do_fetch(0, 0, 2'b00, 0, '0, '0);

    // Slow memory, including an ack on the last allowed cycle.
    do_fetch(4, 0, 2'b00, 0, '0, '0);
    chk("no_err_delay4", mem_err, 1'b0);
    do_fetch(7, 0, 2'b00, 0, '0, '0);
    chk("no_err_delay7", mem_err, 1'b0);

    // Downstream stall held five cycles from the ack.
    do_fetch(0, 5, 2'b00, 0, '0, '0);

    // Branch and jump together at pc=8: jump wins.
    do_reset(2);
    do_fetch(0, 0, 2'b00, 0, '0, '0);
    do_fetch(0, 0, 2'b00, 0, '0, '0);
    do_fetch(0, 0, 2'b11, 2, 32'd3, 26'h10);
    do_fetch(0, 0, 2'b00, 0, '0, '0);

    // Redirect in the advance cycle is deferred to the following advance.
    do_fetch(0, 0, 2'b01, 4, 32'd1, '0);
    do_fetch(0, 0, 2'b00, 0, '0, '0);
    do_fetch(1, 0, 2'b00, 0, '0, '0);

    // Branch during a stall lands on END_ADDR, then fetch halts.
    do_reset(2);
    do_fetch(0, 0, 2'b10, 2, '0, 26'h18);
    do_fetch(0, 3, 2'b01, 3, 32'd2, '0);
    wait_req();
    chk("end_req_seen", imem_req, 1'b1);
    chk("end_pc", pc, 32'h6c);
    tick();
    chk("end_halted", {halted, mem_err, imem_req, pause}, 4'b1001);

    // Same path, but reset lands in the middle of the stall.
    do_reset(2);
    do_fetch(0, 0, 2'b10, 2, '0, 26'h18);
    wait_req();
    imem_ack  = 1'b1;
    stall_req = 1'b1;
    tick();
    imem_ack  = 1'b0;
    br_req    = 1'b1;
    br_offset = 32'd2;
    tick();
    do_reset(1);
    do_fetch(0, 0, 2'b00, 0, '0, '0);

    // imem never answers.
    do_reset(2);
    wait_req();
    cnt = 0;
    while (imem_req === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("timeout_req_cycles", 64'(cnt), 64'd8);
    chk("timeout_halt", {halted, mem_err, imem_req, pause}, 4'b1101);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        j_req    = 1'b1;
        j_target = 26'h5;
      end
      tick();
      imem_ack = (i == 5);
      ok = ok && pause && halted && mem_err && !imem_req && !Jump;
    end
    chk("halt_sticky", ok, 1'b1);

    // Randomized traffic.
    do_reset(3);
    for (int n = 0; n < 60; n++) begin
      d    = $urandom_range(0, 5);
      s    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      kind = 2'($urandom_range(0, 3));
      when = $urandom_range(1, 4);
      if (m_pc >= 32'h40 && !m_pj) kind = 2'b10;
      do_fetch(d, s, kind, when, 32'($urandom_range(0, 3)), 26'($urandom_range(0, 8)));
    end
    tick();
    tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("rand_no_err", {mem_err, halted}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
